// File: rtl/cnn_pkg.sv
// Shared constants and FSM state type for the CNN grid output streamer.
package cnn_pkg;
  localparam int unsigned WIDTH   = 9;
  localparam int unsigned GRID    = 4;
  localparam int unsigned N_CELLS = 16;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic [0:0] {ST_IDLE, ST_STREAM} state_e;
endpackage

// File: rtl/cnn_snapshot_bank.sv
// Snapshot register file with indexed read, plus a history bank for frame-to-frame compare.
module cnn_snapshot_bank #(
  parameter int unsigned WIDTH   = 9,
  parameter int unsigned N_CELLS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       commit,
  input  logic [N_CELLS*WIDTH-1:0]   din,
  input  logic [3:0]                 rd_idx,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       match
);
  logic [WIDTH-1:0] snap_q [N_CELLS];
  logic [WIDTH-1:0] hist_q [N_CELLS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N_CELLS); i++) begin
        snap_q[i] <= '0;
        hist_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_CELLS); i++) begin
        if (load)   snap_q[i] <= din[i*WIDTH +: WIDTH];
        if (commit) hist_q[i] <= snap_q[i];
      end
    end
  end

  assign rd_data = snap_q[rd_idx];

  // Compares the live input against history so the result is ready at the capture edge.
  always_comb begin
    match = 1'b1;
    for (int i = 0; i < int'(N_CELLS); i++) begin
      if (din[i*WIDTH +: WIDTH] != hist_q[i]) match = 1'b0;
    end
  end
endmodule

// File: rtl/cnn_grid_result_streamer.sv
// Snapshots the parallel grid outputs on capture and streams them row-major with valid/ready framing.
module cnn_grid_result_streamer #(
  parameter int unsigned WIDTH     = 9,
  parameter int unsigned GRID      = 4,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [GRID*GRID*WIDTH-1:0]  y_flat,
  input  logic                        capture,
  output logic                        cap_ready,
  output logic [WIDTH-1:0]            px_data,
  output logic [3:0]                  px_idx,
  output logic                        px_valid,
  input  logic                        px_ready,
  output logic                        px_sof,
  output logic                        px_eof,
  output logic                        frame_stable,
  output logic [CNT_WIDTH-1:0]        frame_count,
  output logic                        overrun
);
  import cnn_pkg::*;

  localparam logic [3:0] LastIdx = 4'(GRID * GRID - 1);

  state_e state_q;
  logic   have_prev_q;
  logic   load;
  logic   commit;
  logic   match;

  assign cap_ready = (state_q == ST_IDLE);
  assign load      = capture & cap_ready;
  assign commit    = (state_q == ST_STREAM) & px_ready & (px_idx == LastIdx);

  cnn_snapshot_bank #(
    .WIDTH   (WIDTH),
    .N_CELLS (GRID * GRID)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .commit  (commit),
    .din     (y_flat),
    .rd_idx  (px_idx),
    .rd_data (px_data),
    .match   (match)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      px_valid     <= 1'b0;
      px_idx       <= '0;
      px_sof       <= 1'b0;
      px_eof       <= 1'b0;
      frame_stable <= 1'b0;
      frame_count  <= '0;
      overrun      <= 1'b0;
      have_prev_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (capture) begin
            state_q      <= ST_STREAM;
            px_valid     <= 1'b1;
            px_idx       <= '0;
            px_sof       <= 1'b1;
            px_eof       <= 1'b0;
            frame_stable <= have_prev_q & match;
          end
        end
        ST_STREAM: begin
          // Capture is never accepted while streaming, including the EOF cycle.
          if (capture) overrun <= 1'b1;
          if (px_ready) begin
            px_sof <= 1'b0;
            if (px_idx == LastIdx) begin
              state_q     <= ST_IDLE;
              px_valid    <= 1'b0;
              px_idx      <= '0;
              px_eof      <= 1'b0;
              frame_count <= frame_count + CNT_WIDTH'(1);
              have_prev_q <= 1'b1;
            end else begin
              px_idx <= px_idx + 4'd1;
              px_eof <= (px_idx == LastIdx - 4'd1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cnn_grid_result_streamer.sv
// Randomized self-checking bench for cnn_grid_result_streamer against a frame-level model.
module tb_cnn_grid_result_streamer;
  localparam int W = 9;

  logic            clk = 1'b0;
  logic            rst;
  logic [16*W-1:0] y_flat;
  logic            capture;
  logic            cap_ready;
  logic [W-1:0]    px_data;
  logic [3:0]      px_idx;
  logic            px_valid;
  logic            px_ready;
  logic            px_sof;
  logic            px_eof;
  logic            frame_stable;
  logic [7:0]      frame_count;
  logic            overrun;

  always #5 clk = ~clk;

  cnn_grid_result_streamer #(
    .WIDTH     (W),
    .GRID      (4),
    .CNT_WIDTH (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .y_flat       (y_flat),
    .capture      (capture),
    .cap_ready    (cap_ready),
    .px_data      (px_data),
    .px_idx       (px_idx),
    .px_valid     (px_valid),
    .px_ready     (px_ready),
    .px_sof       (px_sof),
    .px_eof       (px_eof),
    .frame_stable (frame_stable),
    .frame_count  (frame_count),
    .overrun      (overrun)
  );

  int checks = 0;
  int errors = 0;

  // Frame-level reference state
  logic [W-1:0] cur  [16];
  logic [W-1:0] hist [16];
  bit           have_prev;
  int           exp_count;
  bit           exp_overrun;

  function automatic logic [16*W-1:0] pack_cur();
    logic [16*W-1:0] v;
    for (int i = 0; i < 16; i++) v[i*W +: W] = cur[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) hist[i] = '0;
    have_prev   = 0;
    exp_count   = 0;
    exp_overrun = 0;
  endtask

  // mode: 0 ready always, 1 pattern 1,0,0, 2 random. inject: captures at idx 5 and in EOF cycle.
  task automatic run_frame(input int mode, input bit inject, input bit scramble);
    int beat, cycles;
    bit done, rdy, exp_stable, mid_done;
    exp_stable = have_prev;
    for (int i = 0; i < 16; i++) if (cur[i] !== hist[i]) exp_stable = 0;
    checks++;
    if (cap_ready !== 1'b1) begin
      errors++; $display("FAIL cap_ready_idle: got %b want 1", cap_ready);
    end
    y_flat = pack_cur(); capture = 1'b1; px_ready = 1'b0;
    @(posedge clk); #1; capture = 1'b0;
    beat = 0; cycles = 0; done = 0; mid_done = 0;
    while (!done && cycles < 400) begin
      checks++;
      if (px_valid !== 1'b1) begin
        errors++; $display("FAIL px_valid beat %0d: got %b want 1", beat, px_valid);
      end
      checks++;
      if (px_idx !== beat[3:0]) begin
        errors++; $display("FAIL px_idx: got %0d want %0d", px_idx, beat);
      end
      checks++;
      if (px_data !== cur[beat]) begin
        errors++;
        $display("FAIL px_data idx %0d: got %0d want %0d", beat, $signed(px_data),
                 $signed(cur[beat]));
      end
      checks++;
      if (px_sof !== (beat == 0) || px_eof !== (beat == 15)) begin
        errors++;
        $display("FAIL sof_eof idx %0d: got %b%b want %b%b", beat, px_sof, px_eof,
                 beat == 0, beat == 15);
      end
      checks++;
      if (frame_stable !== exp_stable || cap_ready !== 1'b0) begin
        errors++;
        $display("FAIL stable_capready: got %b/%b want %b/0", frame_stable, cap_ready, exp_stable);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cycles % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      px_ready = rdy;
      capture  = 1'b0;
      if (inject) begin
        if (beat == 5 && !mid_done) begin
          capture = 1'b1; mid_done = 1; exp_overrun = 1;
        end else if (beat == 15 && rdy) begin
          capture = 1'b1; exp_overrun = 1;
        end
      end
      if (scramble) y_flat = {$urandom, $urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1; capture = 1'b0; cycles++;
      if (rdy) begin
        if (beat == 15) done = 1; else beat++;
      end
    end
    px_ready = 1'b0;
    checks++;
    if (!done) begin
      errors++; $display("FAIL frame_timeout: got %0d beats want 16", beat);
    end
    exp_count = (exp_count + 1) % 256;
    for (int i = 0; i < 16; i++) hist[i] = cur[i];
    have_prev = 1;
    checks++;
    if (px_valid !== 1'b0 || cap_ready !== 1'b1) begin
      errors++; $display("FAIL post_eof: valid %b cap_ready %b want 0/1", px_valid, cap_ready);
    end
    checks++;
    if (frame_count !== 8'(exp_count)) begin
      errors++; $display("FAIL frame_count: got %0d want %0d", frame_count, exp_count);
    end
    checks++;
    if (overrun !== exp_overrun) begin
      errors++; $display("FAIL overrun: got %b want %b", overrun, exp_overrun);
    end
    if (mode == 0) begin
      checks++;
      if (cycles != 16) begin
        errors++; $display("FAIL back_to_back: got %0d cycles want 16", cycles);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; capture = 1'b0; px_ready = 1'b0; y_flat = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    model_reset();
    checks++;
    if (px_valid !== 0 || px_idx !== 0 || px_data !== 0 || px_sof !== 0 || px_eof !== 0) begin
      errors++;
      $display("FAIL reset_px: got v%b i%0d d%0d s%b e%b want all 0", px_valid, px_idx,
               px_data, px_sof, px_eof);
    end
    checks++;
    if (frame_stable !== 0 || frame_count !== 0 || overrun !== 0 || cap_ready !== 1) begin
      errors++;
      $display("FAIL reset_status: got st%b cnt%0d ov%b cr%b want 0/0/0/1", frame_stable,
               frame_count, overrun, cap_ready);
    end
  endtask

  task automatic test_basic();
    for (int k = 1; k <= 16; k++) cur[k-1] = W'(k - 8);
    run_frame(0, 0, 1);
  endtask

  task automatic test_stable();
    run_frame(0, 0, 0);
    cur[8] = W'(2);
    run_frame(0, 0, 0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 16; i++) cur[i] = W'($urandom_range(0, 511));
    run_frame(1, 0, 1);
    for (int i = 0; i < 16; i++) cur[i] = W'($urandom_range(0, 511));
    run_frame(2, 0, 1);
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 16; i++) cur[i] = W'($urandom_range(0, 511));
    run_frame(0, 1, 1);
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (px_valid !== 1'b0) begin
        errors++; $display("FAIL dropped_capture_started: got valid %b want 0", px_valid);
      end
    end
    run_frame(2, 1, 0);
  endtask

  task automatic test_wrap();
    test_reset();
    for (int f = 0; f < 256; f++) begin
      if (f == 0) begin
        for (int i = 0; i < 16; i++) cur[i] = (i % 2 == 0) ? 9'h100 : 9'h0FF;
      end else if (f % 5 != 0) begin
        for (int i = 0; i < 16; i++) cur[i] = W'($urandom_range(0, 511));
      end
      run_frame(f % 3, 0, f % 2 == 1);
    end
    checks++;
    if (frame_count !== 8'd0) begin
      errors++; $display("FAIL frame_count_wrap: got %0d want 0", frame_count);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    for (int i = 0; i < 16; i++) cur[i] = W'($urandom_range(0, 511));
    y_flat = pack_cur(); capture = 1'b1; px_ready = 1'b1;
    @(posedge clk); #1; capture = 1'b0;
    n = 0;
    while (px_idx !== 4'd7 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (px_idx !== 4'd7) begin
      errors++; $display("FAIL reach_idx7: got %0d want 7", px_idx);
    end
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; px_ready = 1'b0;
    model_reset();
    checks++;
    if (px_valid !== 0 || frame_count !== 8'(exp_count) || overrun !== 0 || cap_ready !== 1) begin
      errors++;
      $display("FAIL reset_mid: got v%b cnt%0d ov%b cr%b want 0/%0d/0/1", px_valid,
               frame_count, overrun, cap_ready, exp_count);
    end
    run_frame(0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stable();
    test_backpressure();
    test_overrun();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
